// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: shares one 64-point FFT core between two frame
// requesters. Round-robin launch FSM, tag FIFO of frames in flight, output
// burst routing, and a watchdog for frames whose output never appears.
// Optional statistics counters are enabled with `define FFT_SCHED_STATS_EN.
module fft_frame_scheduler #(
    parameter int MAX_INFLIGHT = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_mode,
    output logic [1:0]  grant,
    output logic [1:0]  src_rd,
    output logic [5:0]  src_idx,
    input  logic [31:0] ch0_data,
    input  logic [31:0] ch1_data,
    output logic [31:0] In_Stream,
    output logic        Mode,
    output logic        Data_Start,
    input  logic        next_data,
    input  logic [31:0] Out_Stream,
    input  logic        Data_Out,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_ch,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        err_timeout
`ifdef FFT_SCHED_STATS_EN
    ,
    output logic [15:0] frames_ch0,
    output logic [15:0] frames_ch1,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP} state_t;

    state_t          state_q;
    logic [1:0]      grant_q, src_rd_q;
    logic [5:0]      src_idx_q;
    logic            mode_q;
    logic            last_q;
    logic [GW-1:0]   gap_q;

    logic [31:0]     in_stream_q;
    logic            data_start_q;

    logic            tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;

    logic            cap_act_q, cap_drop_q, drop_pend_q;
    logic [5:0]      cap_cnt_q;
    logic            out_valid_q, out_ch_q, out_last_q;
    logic [31:0]     out_data_q;
    logic [5:0]      out_idx_q;

    logic [WW-1:0]   wd_q;
    logic            err_q;

    logic            win, launch, fifo_full, fifo_nonempty, head_tag;
    logic            push, pop, cap_start, cap_route, wd_run, wd_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Round-robin winner: on a tie the last-granted channel loses.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) win = ~last_q;
        else              win = req[1];
    end

    assign fifo_full     = (cnt_q == CW'(MAX_INFLIGHT));
    assign fifo_nonempty = (cnt_q != '0);
    assign head_tag      = tag_mem[rp_q];
    assign launch        = (state_q == S_IDLE) && (req != 2'b00) && next_data && !fifo_full;
    assign push          = launch;
    assign cap_start     = Data_Out && !cap_act_q;
    assign cap_route     = cap_start && fifo_nonempty && !drop_pend_q;
    assign pop           = cap_act_q && !cap_drop_q && (cap_cnt_q == 6'd62);
    // Only frames whose input has fully gone into the core can be late.
    assign wd_run        = (cnt_q > CW'(state_q == S_LOAD)) && !cap_act_q;
    assign wd_fire       = wd_run && !Data_Out && (wd_q == WW'(TIMEOUT - 1));

    // Launch FSM: arbitrate, stream 64 source reads, then enforce the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            src_rd_q  <= 2'b00;
            src_idx_q <= 6'd0;
            mode_q    <= 1'b0;
            last_q    <= 1'b1;
            gap_q     <= '0;
        end else begin
            grant_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        grant_q   <= win ? 2'b10 : 2'b01;
                        src_rd_q  <= win ? 2'b10 : 2'b01;
                        src_idx_q <= 6'd0;
                        mode_q    <= req_mode[win];
                        last_q    <= win;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (src_idx_q == 6'd63) begin
                        src_rd_q  <= 2'b00;
                        src_idx_q <= 6'd0;
                        gap_q     <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        src_idx_q <= src_idx_q + 6'd1;
                    end
                end
                S_GAP: begin
                    // First GAP cycle still carries sample 63 on In_Stream.
                    if (gap_q == GW'(GAP_CYCLES)) state_q <= S_IDLE;
                    else                          gap_q   <= gap_q + GW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Core input register: one cycle behind the source read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_stream_q  <= 32'd0;
            data_start_q <= 1'b0;
        end else begin
            data_start_q <= |src_rd_q;
            in_stream_q  <= src_rd_q[1] ? ch1_data :
                            src_rd_q[0] ? ch0_data : 32'd0;
        end
    end

    // Tag FIFO: push on launch, pop on the last output sample, flush on timeout.
    always_ff @(posedge clk) begin
        if (rst || wd_fire) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                tag_mem[wp_q] <= win;
                wp_q          <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Return path: capture 64 samples from Data_Out, routed or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_act_q   <= 1'b0;
            cap_drop_q  <= 1'b0;
            cap_cnt_q   <= 6'd0;
            drop_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_ch_q    <= 1'b0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            if (wd_fire) drop_pend_q <= 1'b1;
            if (cap_start) begin
                cap_act_q   <= 1'b1;
                cap_drop_q  <= !cap_route;
                cap_cnt_q   <= 6'd0;
                out_valid_q <= cap_route;
                out_data_q  <= cap_route ? Out_Stream : 32'd0;
                out_ch_q    <= cap_route ? head_tag : out_ch_q;
                out_idx_q   <= 6'd0;
                out_last_q  <= 1'b0;
                if (!cap_route) drop_pend_q <= 1'b0;
            end else if (cap_act_q) begin
                cap_cnt_q   <= cap_cnt_q + 6'd1;
                out_valid_q <= !cap_drop_q;
                out_data_q  <= cap_drop_q ? 32'd0 : Out_Stream;
                out_idx_q   <= cap_drop_q ? 6'd0 : cap_cnt_q + 6'd1;
                out_last_q  <= !cap_drop_q && (cap_cnt_q == 6'd62);
                if (cap_cnt_q == 6'd62) cap_act_q <= 1'b0;
            end else begin
                out_valid_q <= 1'b0;
                out_data_q  <= 32'd0;
                out_idx_q   <= 6'd0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Watchdog on the oldest in-flight frame; error flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!wd_run || wd_fire) wd_q <= '0;
            else                    wd_q <= wd_q + WW'(1);
            if (wd_fire) err_q <= 1'b1;
        end
    end

`ifdef FFT_SCHED_STATS_EN
    logic [15:0] frames_ch0_q, frames_ch1_q;
    logic [7:0]  drop_cnt_q;

    // Per-channel completed frames (wrapping) and dropped bursts (saturating).
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_ch0_q <= 16'd0;
            frames_ch1_q <= 16'd0;
            drop_cnt_q   <= 8'd0;
        end else begin
            if (pop && !head_tag) frames_ch0_q <= frames_ch0_q + 16'd1;
            if (pop &&  head_tag) frames_ch1_q <= frames_ch1_q + 16'd1;
            if (cap_start && !cap_route && drop_cnt_q != 8'd255)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign frames_ch0 = frames_ch0_q;
    assign frames_ch1 = frames_ch1_q;
    assign drop_cnt   = drop_cnt_q;
`endif

    assign grant       = grant_q;
    assign src_rd      = src_rd_q;
    assign src_idx     = src_idx_q;
    assign In_Stream   = in_stream_q;
    assign Mode        = mode_q;
    assign Data_Start  = data_start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;
    assign busy        = fifo_nonempty || (state_q != S_IDLE);
    assign err_timeout = err_q;

endmodule
